// File: rtl/sobel_magnitude_if.sv
// ---------------------------------------------------------------------------
// sobel_magnitude_if
// Stream bundle between the gradient convolution stage, the magnitude block
// and the pixel writeback path.
//   valid_i/ready_o     : input handshake for one (gx, gy) gradient pair
//   gx_i/gy_i           : signed gradients, 2*WIDTH_P bits
//   thresh_i            : edge threshold, quasi-static
//   valid_o/ready_i     : output handshake for one magnitude beat
//   mag_o/edge_o/last_o : saturated magnitude, edge flag, end-of-frame marker
// slave  modport : the magnitude block itself
// master modport : whatever drives gradients in and consumes results
// ---------------------------------------------------------------------------
interface sobel_magnitude_if #(
    parameter int WIDTH_P = 8
);
    logic                        valid_i;
    logic                        ready_o;
    logic signed [2*WIDTH_P-1:0] gx_i;
    logic signed [2*WIDTH_P-1:0] gy_i;
    logic        [WIDTH_P-1:0]   thresh_i;
    logic                        valid_o;
    logic                        ready_i;
    logic        [WIDTH_P-1:0]   mag_o;
    logic                        edge_o;
    logic                        last_o;

    modport slave (
        input  valid_i, gx_i, gy_i, thresh_i, ready_i,
        output ready_o, valid_o, mag_o, edge_o, last_o
    );

    modport master (
        output valid_i, gx_i, gy_i, thresh_i, ready_i,
        input  ready_o, valid_o, mag_o, edge_o, last_o
    );
endinterface

// File: rtl/sobel_magnitude.sv
// ---------------------------------------------------------------------------
// sobel_magnitude
// Turns a stream of signed Sobel gradient pairs into a saturated L1 edge
// magnitude |gx|+|gy| with a threshold edge flag and an end-of-frame marker.
// Raster position is tracked with column/row counters; pixels whose 3x3
// window was incomplete (first two rows / first two columns) come out as 0.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : sobel_magnitude_if.slave stream bundle (both handshakes,
//            gradients, threshold, magnitude/edge/last results)
// Two-stage valid/ready pipeline: stage 1 holds absolute values and the
// position flags, stage 2 holds the registered results.
// ---------------------------------------------------------------------------
module sobel_magnitude #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    sobel_magnitude_if.slave bus
);
    localparam int GW_L    = 2 * WIDTH_P;
    localparam int COL_W_L = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
    localparam int ROW_W_L = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam logic [GW_L:0] MAX_L = {{(GW_L + 1 - WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

    logic               v1, v2;
    logic               adv1, adv2, accept;
    logic [COL_W_L-1:0] col;
    logic [ROW_W_L-1:0] row;
    logic               col_last, row_last;
    logic [GW_L-1:0]    ax_next, ay_next;
    logic [GW_L-1:0]    ax, ay;
    logic               mask, lst;
    logic [GW_L:0]      sum;
    logic [WIDTH_P-1:0] sat_mag;
    logic [WIDTH_P-1:0] mag_q;
    logic               edge_q, last_q;

    // Stage 2 frees when empty or drained; stage 1 frees when empty or moving on.
    assign adv2   = !v2 | bus.ready_i;
    assign adv1   = !v1 | adv2;
    assign accept = bus.valid_i & adv1;

    assign bus.ready_o = adv1;
    assign bus.valid_o = v2;
    assign bus.mag_o   = mag_q;
    assign bus.edge_o  = edge_q;
    assign bus.last_o  = last_q;

    // Negation in 2*WIDTH_P bits read back as unsigned, so the most negative
    // gradient maps to its exact magnitude rather than wrapping to a sign error.
    assign ax_next = bus.gx_i[GW_L-1] ? $unsigned(-bus.gx_i) : $unsigned(bus.gx_i);
    assign ay_next = bus.gy_i[GW_L-1] ? $unsigned(-bus.gy_i) : $unsigned(bus.gy_i);

    assign col_last = (col == COL_W_L'(DEPTH_P - 1));
    assign row_last = (row == ROW_W_L'(HEIGHT_P - 1));

    assign sum     = {1'b0, ax} + {1'b0, ay};
    assign sat_mag = (sum > MAX_L) ? {WIDTH_P{1'b1}} : sum[WIDTH_P-1:0];

    // Raster counters move only on an accepted beat, so stalls never skew
    // the masking or the end-of-frame marker.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage 1: absolute gradients plus position flags of the accepted beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1   <= 1'b0;
            ax   <= '0;
            ay   <= '0;
            mask <= 1'b0;
            lst  <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.valid_i;
            if (bus.valid_i) begin
                ax   <= ax_next;
                ay   <= ay_next;
                mask <= (32'(row) < 32'd2) | (32'(col) < 32'd2);
                lst  <= row_last & col_last;
            end
        end
    end

    // Stage 2: saturated magnitude and edge decision; held while stalled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v2     <= 1'b0;
            mag_q  <= '0;
            edge_q <= 1'b0;
            last_q <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                mag_q  <= mask ? '0 : sat_mag;
                edge_q <= !mask && (sat_mag >= bus.thresh_i);
                last_q <= lst;
            end
        end
    end
endmodule

// File: doc/sobel_magnitude.md
Name: sobel_magnitude

Overview:
Consumer end of the Sobel gradient stream. Accepts one signed (gx, gy) gradient pair per beat over a valid/ready handshake. Produces a saturated L1 edge magnitude |gx|+|gy| per beat, plus a threshold edge flag and an end-of-frame marker. Tracks raster position with column/row counters, so that results whose 3x3 window is incomplete (first two columns of every row, first two rows of every frame) are forced to zero. Sits directly downstream of the gradient convolution stage and feeds the pixel output/writeback path.

Parameters:
WIDTH_P, 8, pixel bit width; gradients are 2*WIDTH_P bits signed
DEPTH_P, 16, pixels per image row
HEIGHT_P, 16, rows per frame

Ports:
clk_i  input  1  clock, all state on rising edge
rstn_i  input  1  asynchronous active-low reset
valid_i  input  1  gradient pair valid
ready_o  output  1  block can accept a gradient pair this cycle
gx_i  input  2*WIDTH_P  signed horizontal gradient
gy_i  input  2*WIDTH_P  signed vertical gradient
thresh_i  input  WIDTH_P  edge threshold; quasi-static, sampled at stage-2 capture
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts output beat
mag_o  output  WIDTH_P  saturated magnitude, 0 when masked
edge_o  output  1  mag_o >= thresh_i and not masked
last_o  output  1  beat is the final pixel of the frame (row HEIGHT_P-1, col DEPTH_P-1)

Behaviour:
- Reset: rstn_i low asynchronously clears all stage valids, counters, mag_o, edge_o, last_o and valid_o to 0. Reset mid-frame discards in-flight beats; the next accepted beat is treated as row 0, col 0.
- Handshake:
  - Input accepted when valid_i & ready_o.
  - Output consumed when valid_o & ready_i.
  - valid_o must not drop, and mag_o/edge_o/last_o must stay stable, while ready_i is low.
  - Exactly one output beat per accepted input beat, in order, with no drops or duplicates.
- Pipeline: two registered stages, v1 and v2.
  - adv2 = !v2 | ready_i.
  - adv1 = !v1 | adv2.
  - ready_o = adv1 (combinational from ready_i is permitted).
  - Latency: an accepted beat appears on valid_o 2 cycles later when unstalled. Sustained throughput is 1 beat/cycle.
- Stage 1, on accept:
  - Register ax = |gx_i| and ay = |gy_i| as unsigned 2*WIDTH_P bits. The most negative gradient -2^(2W-1) maps to 2^(2W-1) with no overflow.
  - Register mask = (row < 2) | (col < 2).
  - Register lst = (row == HEIGHT_P-1) & (col == DEPTH_P-1).
- Counters advance only on accept:
  - col increments and wraps DEPTH_P-1 -> 0.
  - On the col wrap, row increments and wraps HEIGHT_P-1 -> 0.
- Stage 2, on adv2 with v1:
  - sum = ax + ay, 2*WIDTH_P+1 bits.
  - mag = (sum > 2^WIDTH_P-1) ? 2^WIDTH_P-1 : sum[WIDTH_P-1:0].
  - If mask is set: mag_o = 0 and edge_o = 0. Otherwise mag_o = mag and edge_o = (mag >= thresh_i).
  - last_o = lst.
  - valid_o = v1 on adv2; it holds otherwise.
- Simultaneous events: accept and output in the same cycle is a normal pass-through with no bubble. During a full stall (v1 & v2 & !ready_i), ready_o = 0 and the counters are frozen.

Test Plan:
- DEPTH_P=4, HEIGHT_P=4, ready_i=1, 16 beats of gx=10, gy=-5, thresh_i=12:
  - Beats with row<2 or col<2 give mag_o=0, edge_o=0.
  - Beats 10, 11, 14, 15 give mag_o=15, edge_o=1.
  - last_o is high only on beat 15.
  - Each output appears 2 cycles after its input.
- Saturation, unmasked position, gx=200, gy=100 -> mag_o=255. Separately, gx=-32768, gy=0 -> mag_o=255, with no sign error.
- Threshold boundary, unmasked: gx=30, gy=0. thresh_i=30 -> edge_o=1; thresh_i=31 -> edge_o=0.
- Backpressure:
  - Continuous valid_i, with ready_i held low for 5 cycles: after 2 beats ready_o=0.
  - Outputs stay stable while stalled; on release, all beats emerge in order with none lost or duplicated.
  - The counters stay aligned, so last_o still lands on frame beat 15.
- Reset mid-frame after 7 beats, with 2 beats in flight:
  - valid_o drops to 0 immediately on rstn_i low.
  - After release, the next frame's first two rows are masked again, and last_o occurs on the 16th new beat.
- Random valid_i/ready_i toggling over 3 frames: the output stream matches a reference model beat-for-beat, and last_o appears once per 16 beats.
